// File: rtl/tff_count_ctrl.sv
// Sequencer for a bank of external T flip-flops. It drives the per-bit toggle
// enables so the bank loads a preset and then counts up or down to a target.
module tff_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             up_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic [WIDTH-1:0] q_in_i,
  output logic [WIDTH-1:0] tin_o,
  output logic             bank_reset_o,
  output logic             busy_o,
  output logic             tc_o,
  output logic             done_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             up_q, up_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             busy_q, done_q;

  logic [WIDTH-1:0] preset, target;
  logic [WIDTH-1:0] inc_tin, dec_tin;
  logic             inc_c, dec_c;

  assign preset       = up_q ? '0 : limit_q;
  assign target       = up_q ? limit_q : '0;
  assign tc_o         = (state_q == S_RUN) && (q_in_i == target);
  assign bank_reset_o = reset_i;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

  // The bank shares this clock, so everything moves on the falling edge.
  always_ff @(negedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      up_q    <= 1'b0;
      limit_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      up_q    <= up_d;
      limit_q <= limit_d;
      busy_q  <= (state_d == S_LOAD) || (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    up_d    = up_q;
    limit_d = limit_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_LOAD;
        up_d    = up_i;
        limit_d = limit_i;
      end
      S_LOAD: state_d = stop_i ? S_IDLE : S_RUN;
      S_RUN: begin
        if (stop_i)    state_d = S_IDLE;
        else if (tc_o) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Ripple toggle chains: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    inc_tin = '0;
    dec_tin = '0;
    inc_c   = 1'b1;
    dec_c   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      inc_tin[i] = inc_c;
      dec_tin[i] = dec_c;
      inc_c      = inc_c & q_in_i[i];
      dec_c      = dec_c & ~q_in_i[i];
    end
  end

  always_comb begin
    tin_o = '0;
    if (!reset_i) begin
      case (state_q)
        S_LOAD: tin_o = q_in_i ^ preset;
        S_RUN:  if (!stop_i && !tc_o) tin_o = up_q ? inc_tin : dec_tin;
        default: tin_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Bench for tff_count_ctrl: a behavioural TFF bank plus an arithmetic model of
// the run sequence, compared every cycle, with directed runs pinning key values.
module tb_tff_count_ctrl;
  localparam int W = 4;
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DONE = 3;

  logic         clk = 1'b1;
  logic         reset, start, stop, up;
  logic [W-1:0] limit;
  logic [W-1:0] tin;
  logic         bank_reset, busy, tc, done;

  logic [W-1:0] q_bank = '0;
  logic         load_req;
  logic [W-1:0] load_val;

  int           ph = P_IDLE;
  logic         m_up = 1'b0;
  logic [W-1:0] m_lim = '0;
  bit           chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  tff_count_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .stop_i(stop), .up_i(up),
    .limit_i(limit), .q_in_i(q_bank), .tin_o(tin), .bank_reset_o(bank_reset),
    .busy_o(busy), .tc_o(tc), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // External T flip-flop bank.
  always @(negedge clk) begin
    if (load_req)        q_bank <= load_val;
    else if (bank_reset) q_bank <= '0;
    else                 q_bank <= q_bank ^ tin;
  end

  function automatic logic [W-1:0] m_target();
    return m_up ? m_lim : '0;
  endfunction

  // Reference sequence: load preset, step by +/-1 until the target, pulse done.
  always @(negedge clk) begin
    if (reset) begin
      ph <= P_IDLE; m_up <= 1'b0; m_lim <= '0;
    end else begin
      case (ph)
        P_IDLE: if (start) begin ph <= P_LOAD; m_up <= up; m_lim <= limit; end
        P_LOAD: ph <= stop ? P_IDLE : P_RUN;
        P_RUN:  if (stop) ph <= P_IDLE; else if (q_bank == m_target()) ph <= P_DONE;
        default: ph <= P_IDLE;
      endcase
    end
  end

  always @(posedge clk) begin
    if (chk_en) begin
      logic [W-1:0] e_tin, nxt, pre;
      logic         e_tc;
      e_tc  = (ph == P_RUN) && (q_bank == m_target());
      pre   = m_up ? '0 : m_lim;
      nxt   = m_up ? q_bank + 1'b1 : q_bank - 1'b1;
      e_tin = '0;
      if (!reset && ph == P_LOAD) e_tin = q_bank ^ pre;
      if (!reset && ph == P_RUN && !stop && !e_tc) e_tin = q_bank ^ nxt;
      chk("m_tin",  32'(tin), 32'(e_tin));
      chk("m_tc",   32'(tc), 32'(e_tc));
      chk("m_busy", 32'(busy), 32'(ph == P_LOAD || ph == P_RUN));
      chk("m_done", 32'(done), 32'(ph == P_DONE));
      chk("m_bank_reset", 32'(bank_reset), 32'(reset));
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; up = 1'b0; limit = '0;
    load_req = 1'b1; load_val = 4'b1011;
    tick();
    load_req = 1'b0;
    chk_en = 1'b1;
    chk("rst_bank_preload", 32'(q_bank), 32'hB);
    for (int i = 0; i < 3; i++) begin
      chk("rst_bank_reset", 32'(bank_reset), 32'h1);
      chk("rst_tin", 32'(tin), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      tick();
    end
    reset = 1'b0;
    chk("rst_bank_cleared", 32'(q_bank), 32'h0);
    chk("rst_idle_busy", 32'(busy), 32'h0);

    // Up count 0..5
    start = 1'b1; up = 1'b1; limit = 4'd5;
    tick(); start = 1'b0;
    chk("up_load_busy", 32'(busy), 32'h1);
    for (int i = 0; i <= 5; i++) begin
      tick();
      chk("up_q", 32'(q_bank), 32'(i));
    end
    chk("up_tc", 32'(tc), 32'h1);
    tick();
    chk("up_done", 32'(done), 32'h1);
    chk("up_busy_low", 32'(busy), 32'h0);
    tick();
    chk("up_done_clear", 32'(done), 32'h0);
    chk("up_q_hold", 32'(q_bank), 32'h5);

    // Down count 15..0 from bank at 3
    load_req = 1'b1; load_val = 4'd3;
    tick(); load_req = 1'b0;
    start = 1'b1; up = 1'b0; limit = 4'hF;
    tick(); start = 1'b0;
    chk("dn_load_tin", 32'(tin), 32'hC);
    tick();
    chk("dn_preset", 32'(q_bank), 32'hF);
    for (int i = 14; i >= 0; i--) begin
      tick();
      chk("dn_q", 32'(q_bank), 32'(i));
    end
    tick();
    chk("dn_done", 32'(done), 32'h1);
    tick();
    chk("dn_q_hold", 32'(q_bank), 32'h0);

    // Zero-length run
    start = 1'b1; up = 1'b1; limit = 4'd0;
    tick(); start = 1'b0;
    tick();
    chk("zero_tc", 32'(tc), 32'h1);
    chk("zero_tin", 32'(tin), 32'h0);
    tick();
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_q", 32'(q_bank), 32'h0);
    tick();

    // Abort in RUN at q=3
    start = 1'b1; up = 1'b1; limit = 4'd9;
    tick(); start = 1'b0;
    tick();
    repeat (3) tick();
    chk("abort_q_before", 32'(q_bank), 32'h3);
    stop = 1'b1; #1;
    chk("abort_tin", 32'(tin), 32'h0);
    tick(); stop = 1'b0;
    chk("abort_q_hold", 32'(q_bank), 32'h3);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_no_done", 32'(done), 32'h0);
    tick();
    chk("abort_no_done2", 32'(done), 32'h0);

    // Abort in LOAD leaves the bank at preset
    start = 1'b1; up = 1'b0; limit = 4'd6;
    tick(); start = 1'b0; stop = 1'b1;
    tick(); stop = 1'b0;
    chk("ldabort_q", 32'(q_bank), 32'h6);
    chk("ldabort_busy", 32'(busy), 32'h0);

    // start held through RUN and DONE is ignored
    load_req = 1'b1; load_val = 4'd0;
    tick(); load_req = 1'b0;
    start = 1'b1; up = 1'b1; limit = 4'd3;
    tick();
    limit = 4'd9; up = 1'b0;
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("ign_q", 32'(q_bank), 32'(i));
    end
    tick();
    chk("ign_done", 32'(done), 32'h1);
    tick(); start = 1'b0;
    chk("ign_idle", 32'(busy), 32'h0);
    chk("ign_q_final", 32'(q_bank), 32'h3);

    // Reset mid-run at q=6
    load_req = 1'b1; load_val = 4'd0;
    tick(); load_req = 1'b0;
    start = 1'b1; up = 1'b1; limit = 4'd9;
    tick(); start = 1'b0;
    tick();
    repeat (6) tick();
    chk("rmid_q_before", 32'(q_bank), 32'h6);
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("rmid_q", 32'(q_bank), 32'h0);
    chk("rmid_busy", 32'(busy), 32'h0);
    chk("rmid_done", 32'(done), 32'h0);
    tick();
    chk("rmid_done2", 32'(done), 32'h0);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 600; n++) begin
      start = ($urandom_range(2) == 0);
      stop  = ($urandom_range(24) == 0);
      reset = ($urandom_range(79) == 0);
      up    = 1'($urandom_range(1));
      limit = W'($urandom_range(15));
      tick();
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
